// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master: bus widths and FSM state encoding.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone initiator signals of the command master.
interface wb_cmd_master_if;
    import wb_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [WB_ADR_W-1:0] cmd_adr;
    logic [WB_DAT_W-1:0] cmd_dat;
    logic [WB_SEL_W-1:0] cmd_sel;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WB_DAT_W-1:0] rsp_dat;
    logic                rsp_err;
    logic                rsp_timeout;

    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [WB_SEL_W-1:0] wbm_sel_o;
    logic [WB_ADR_W-1:0] wbm_adr_o;
    logic [WB_DAT_W-1:0] wbm_dat_o;
    logic [WB_DAT_W-1:0] wbm_dat_i;
    logic                wbm_ack_i;
    logic                wbm_err_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_cmd_master_timeout_ctr.sv
// Bus-cycle timeout counter: cleared on command accept, counts silent bus cycles.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT   = TO_W'(TIMEOUT_CYCLES);
    localparam bit              ENABLED = (TIMEOUT_CYCLES != 32'd0);

    logic [TO_W-1:0] count_r;
    logic            expired_s;

    assign expired_s = ENABLED && (count_r == LIMIT);
    assign expired   = expired_s;

    // Counter register; saturates at the limit so expiry stays asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TO_W{1'b0}};
        end else if (clear) begin
            count_r <= {TO_W{1'b0}};
        end else if (enable && ENABLED && !expired_s) begin
            count_r <= count_r + TO_W'(1'b1);
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one bus cycle and one response.
// All bus and response outputs are registered; IDLE -> BUS -> RESP -> IDLE.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_cmd_master_if.master   bus
);

    state_e              state_r;
    state_e              next_state_s;

    logic                accept_s;
    logic                end_ack_s;
    logic                end_err_s;
    logic                end_to_s;
    logic                to_en_s;
    logic                to_expired_s;

    logic                cmd_ready_r;
    logic                cyc_r;
    logic                stb_r;
    logic                we_r;
    logic [WB_SEL_W-1:0] sel_r;
    logic [WB_ADR_W-1:0] adr_r;
    logic [WB_DAT_W-1:0] dat_o_r;
    logic                rsp_valid_r;
    logic [WB_DAT_W-1:0] rsp_dat_r;
    logic                rsp_err_r;
    logic                rsp_timeout_r;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (accept_s),
        .enable  (to_en_s),
        .expired (to_expired_s)
    );

    // Next-state and cycle-termination decode; err beats ack, ack beats timeout.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        end_ack_s    = 1'b0;
        end_err_s    = 1'b0;
        end_to_s     = 1'b0;
        to_en_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = BUS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUS: begin
                if (bus.wbm_err_i) begin
                    end_err_s    = 1'b1;
                    next_state_s = RESP;
                end else if (bus.wbm_ack_i) begin
                    end_ack_s    = 1'b1;
                    next_state_s = RESP;
                end else if (to_expired_s) begin
                    end_to_s     = 1'b1;
                    next_state_s = RESP;
                end else begin
                    to_en_s      = 1'b1;
                    next_state_s = BUS;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State and handshake outputs, registered from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cmd_ready_r <= (next_state_s == IDLE);
            cyc_r       <= (next_state_s == BUS);
            stb_r       <= (next_state_s == BUS);
            rsp_valid_r <= (next_state_s == RESP);
        end
    end

    // Bus request fields captured at accept; response fields captured at cycle end.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_r          <= 1'b0;
            sel_r         <= {WB_SEL_W{1'b0}};
            adr_r         <= {WB_ADR_W{1'b0}};
            dat_o_r       <= {WB_DAT_W{1'b0}};
            rsp_dat_r     <= {WB_DAT_W{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r    <= bus.cmd_we;
                sel_r   <= bus.cmd_sel;
                adr_r   <= bus.cmd_adr;
                dat_o_r <= bus.cmd_dat;
            end
            if (end_ack_s) begin
                rsp_dat_r     <= we_r ? {WB_DAT_W{1'b0}} : bus.wbm_dat_i;
                rsp_err_r     <= 1'b0;
                rsp_timeout_r <= 1'b0;
            end else if (end_err_s) begin
                rsp_dat_r     <= {WB_DAT_W{1'b0}};
                rsp_err_r     <= 1'b1;
                rsp_timeout_r <= 1'b0;
            end else if (end_to_s) begin
                rsp_dat_r     <= {WB_DAT_W{1'b0}};
                rsp_err_r     <= 1'b1;
                rsp_timeout_r <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_dat     = rsp_dat_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.wbm_cyc_o   = cyc_r;
    assign bus.wbm_stb_o   = stb_r;
    assign bus.wbm_we_o    = we_r;
    assign bus.wbm_sel_o   = sel_r;
    assign bus.wbm_adr_o   = adr_r;
    assign bus.wbm_dat_o   = dat_o_r;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: scoreboard of expected responses plus a
// configurable Wishbone responder; TIMEOUT_CYCLES is set to 4.
module tb_wb_cmd_master;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        to;
    } exp_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    exp_t sb_q[$];
    exp_t exp_s;

    // responder configuration: 0 ack, 1 err, 2 ack+err, 3 silent
    int          slv_mode;
    int          slv_wait;
    logic [31:0] slv_data;
    logic        force_ack;
    int          slv_beat;
    int          cyc_total;
    int          stb_no_cyc;

    wb_cmd_master_if bus ();

    wb_cmd_master #(
        .TIMEOUT_CYCLES (4),
        .TO_W           (8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wishbone responder, updated away from the active edge.
    always @(negedge clk) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
            if (slv_mode != 3 && slv_beat == slv_wait) begin
                bus.wbm_ack_i = (slv_mode == 0 || slv_mode == 2);
                bus.wbm_err_i = (slv_mode == 1 || slv_mode == 2);
                bus.wbm_dat_i = slv_data;
            end else begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
                bus.wbm_dat_i = 32'h0;
            end
            slv_beat = slv_beat + 1;
        end else begin
            bus.wbm_ack_i = force_ack;
            bus.wbm_err_i = 1'b0;
            bus.wbm_dat_i = slv_data;
            slv_beat      = 0;
        end
    end

    // Bus activity monitor: cyc cycle count and stb-without-cyc occurrences.
    always @(negedge clk) begin
        if (rst) begin
            cyc_total  = 0;
            stb_no_cyc = 0;
        end else begin
            if (bus.wbm_cyc_o) cyc_total = cyc_total + 1;
            if (bus.wbm_stb_o && !bus.wbm_cyc_o) stb_no_cyc = stb_no_cyc + 1;
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        @(negedge clk);
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared += 5;
        if (bus.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin mismatched++; $display("FAIL reset_cyc_stb got=%b%b want=00", bus.wbm_cyc_o, bus.wbm_stb_o); end
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL reset_rsp got=%b%b%b want=000", bus.rsp_valid, bus.rsp_err, bus.rsp_timeout); end
        if (bus.rsp_dat !== 32'h0 || bus.wbm_adr_o !== 32'h0 || bus.wbm_dat_o !== 32'h0) begin mismatched++; $display("FAIL reset_data got=%h/%h/%h want=0", bus.rsp_dat, bus.wbm_adr_o, bus.wbm_dat_o); end
        if (bus.wbm_we_o !== 1'b0 || bus.wbm_sel_o !== 4'h0) begin mismatched++; $display("FAIL reset_we_sel got=%b/%h want=0/0", bus.wbm_we_o, bus.wbm_sel_o); end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.cmd_ready !== 1'b1 || bus.wbm_cyc_o !== 1'b0) begin mismatched++; $display("FAIL post_reset_idle got ready=%b cyc=%b want 1/0", bus.cmd_ready, bus.wbm_cyc_o); end
    endtask

    task automatic test_write_zero_wait();
        slv_mode = 0; slv_wait = 0; slv_data = 32'h5555_AAAA;
        sb_q.push_back({32'h0, 1'b0, 1'b0});
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        compared += 3;
        if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== 1'b1) begin mismatched++; $display("FAIL wr_cyc_stb_we got=%b%b%b want=111", bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o); end
        if (bus.wbm_adr_o !== 32'h3000_0004 || bus.wbm_dat_o !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL wr_adr_dat got=%h/%h want=30000004/deadbeef", bus.wbm_adr_o, bus.wbm_dat_o); end
        if (bus.wbm_sel_o !== 4'hF || bus.cmd_ready !== 1'b0) begin mismatched++; $display("FAIL wr_sel_ready got=%h/%b want=f/0", bus.wbm_sel_o, bus.cmd_ready); end
        @(negedge clk);
        compared += 2;
        if (bus.rsp_valid !== 1'b1) begin mismatched++; $display("FAIL wr_latency rsp_valid got=%b want=1 two cycles after accept", bus.rsp_valid); end
        if (bus.wbm_cyc_o !== 1'b0) begin mismatched++; $display("FAIL wr_cyc_drop got=%b want=0", bus.wbm_cyc_o); end
        exp_s = sb_q.pop_front();
        compared += 2;
        if (bus.rsp_dat !== exp_s.dat) begin mismatched++; $display("FAIL wr_rsp_dat got=%h want=%h", bus.rsp_dat, exp_s.dat); end
        if (bus.rsp_err !== exp_s.err || bus.rsp_timeout !== exp_s.to) begin mismatched++; $display("FAIL wr_rsp_err got=%b%b want=%b%b", bus.rsp_err, bus.rsp_timeout, exp_s.err, exp_s.to); end
        consume();
    endtask

    task automatic test_read_wait_states();
        int  cyc0, lat;
        bit  ok;
        slv_mode = 0; slv_wait = 3; slv_data = 32'h1234_5678;
        sb_q.push_back({32'h1234_5678, 1'b0, 1'b0});
        cyc0 = cyc_total;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        wait_rsp(lat, ok);
        compared += 3;
        if (!ok) begin mismatched++; $display("FAIL rd_rsp_wait got=none want=rsp_valid"); end
        if (cyc_total - cyc0 !== 4) begin mismatched++; $display("FAIL rd_cyc_len got=%0d want=4", cyc_total - cyc0); end
        if (lat !== 5) begin mismatched++; $display("FAIL rd_latency got=%0d want=5", lat); end
        exp_s = sb_q.pop_front();
        compared += 2;
        if (bus.rsp_dat !== exp_s.dat) begin mismatched++; $display("FAIL rd_rsp_dat got=%h want=%h", bus.rsp_dat, exp_s.dat); end
        if (bus.rsp_err !== exp_s.err || bus.rsp_timeout !== exp_s.to) begin mismatched++; $display("FAIL rd_rsp_err got=%b%b want=%b%b", bus.rsp_err, bus.rsp_timeout, exp_s.err, exp_s.to); end
        consume();
    endtask

    task automatic test_timeout();
        int cyc0, lat;
        bit ok;
        slv_mode = 3; slv_wait = 0; slv_data = 32'hFFFF_0000;
        sb_q.push_back({32'h0, 1'b1, 1'b1});
        cyc0 = cyc_total;
        issue(1'b0, 32'h3000_0020, 32'h0, 4'h3);
        wait_rsp(lat, ok);
        compared += 2;
        if (!ok) begin mismatched++; $display("FAIL to_rsp_wait got=none want=rsp_valid"); end
        if (cyc_total - cyc0 !== 5) begin mismatched++; $display("FAIL to_cyc_len got=%0d want=5", cyc_total - cyc0); end
        exp_s = sb_q.pop_front();
        compared += 2;
        if (bus.rsp_dat !== exp_s.dat) begin mismatched++; $display("FAIL to_rsp_dat got=%h want=%h", bus.rsp_dat, exp_s.dat); end
        if (bus.rsp_err !== exp_s.err || bus.rsp_timeout !== exp_s.to) begin mismatched++; $display("FAIL to_rsp_err got=%b%b want=%b%b", bus.rsp_err, bus.rsp_timeout, exp_s.err, exp_s.to); end
        consume();
    endtask

    task automatic test_bus_error();
        int lat;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            slv_mode = (k == 0) ? 1 : 2;
            slv_wait = (k == 0) ? 1 : 0;
            slv_data = 32'hAAAA_5555;
            sb_q.push_back({32'h0, 1'b1, 1'b0});
            issue(1'b0, 32'h3000_0030 + k, 32'h0, 4'hF);
            wait_rsp(lat, ok);
            exp_s = sb_q.pop_front();
            compared += 3;
            if (!ok) begin mismatched++; $display("FAIL err%0d_rsp_wait got=none want=rsp_valid", k); end
            if (bus.rsp_dat !== exp_s.dat) begin mismatched++; $display("FAIL err%0d_rsp_dat got=%h want=%h", k, bus.rsp_dat, exp_s.dat); end
            if (bus.rsp_err !== exp_s.err || bus.rsp_timeout !== exp_s.to) begin mismatched++; $display("FAIL err%0d_rsp_err got=%b%b want=%b%b", k, bus.rsp_err, bus.rsp_timeout, exp_s.err, exp_s.to); end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        slv_mode = 0; slv_wait = 0; slv_data = 32'hCAFE_F00D;
        sb_q.push_back({32'hCAFE_F00D, 1'b0, 1'b0});
        issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        wait_rsp(lat, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL bp_rsp_wait got=none want=rsp_valid"); end
        sb_q.push_back({32'h0, 1'b0, 1'b0});
        bus.cmd_we    = 1'b1;
        bus.cmd_adr   = 32'h3000_0044;
        bus.cmd_dat   = 32'h0BAD_F00D;
        bus.cmd_sel   = 4'h6;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared += 3;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL bp_hold%0d got=%b/%h want=1/cafef00d", i, bus.rsp_valid, bus.rsp_dat); end
            if (bus.cmd_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready%0d got=%b want=0", i, bus.cmd_ready); end
            if (bus.wbm_cyc_o !== 1'b0) begin mismatched++; $display("FAIL bp_cyc%0d got=%b want=0", i, bus.wbm_cyc_o); end
        end
        exp_s = sb_q.pop_front();
        compared++;
        if (bus.rsp_dat !== exp_s.dat || bus.rsp_err !== exp_s.err) begin mismatched++; $display("FAIL bp_rsp1 got=%h/%b want=%h/%b", bus.rsp_dat, bus.rsp_err, exp_s.dat, exp_s.err); end
        consume();
        @(negedge clk);
        compared++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wbm_cyc_o !== 1'b0) begin mismatched++; $display("FAIL bp_idle_gap got v=%b r=%b c=%b want 0/1/0", bus.rsp_valid, bus.cmd_ready, bus.wbm_cyc_o); end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h3000_0044 || bus.wbm_sel_o !== 4'h6) begin mismatched++; $display("FAIL bp_second_cyc got c=%b adr=%h sel=%h want 1/30000044/6", bus.wbm_cyc_o, bus.wbm_adr_o, bus.wbm_sel_o); end
        wait_rsp(lat, ok);
        exp_s = sb_q.pop_front();
        compared++;
        if (!ok || bus.rsp_dat !== exp_s.dat || bus.rsp_err !== exp_s.err) begin mismatched++; $display("FAIL bp_rsp2 got ok=%b %h/%b want 1 %h/%b", ok, bus.rsp_dat, bus.rsp_err, exp_s.dat, exp_s.err); end
        consume();
    endtask

    task automatic test_reset_mid_bus();
        slv_mode = 3; slv_wait = 0; slv_data = 32'h7777_7777;
        issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        compared++;
        if (bus.wbm_cyc_o !== 1'b1) begin mismatched++; $display("FAIL rst_pre_cyc got=%b want=1", bus.wbm_cyc_o); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        compared += 2;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin mismatched++; $display("FAIL rst_cyc_stb got=%b%b want=00", bus.wbm_cyc_o, bus.wbm_stb_o); end
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_idle got ready=%b rsp=%b want 1/0", bus.cmd_ready, bus.rsp_valid); end
        force_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0) begin mismatched++; $display("FAIL rst_late_ack%0d got rsp=%b cyc=%b want 0/0", i, bus.rsp_valid, bus.wbm_cyc_o); end
        end
        force_ack = 1'b0;
        compared += 2;
        if (sb_q.size() !== 0) begin mismatched++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
        if (stb_no_cyc !== 0) begin mismatched++; $display("FAIL stb_without_cyc got=%0d want=0", stb_no_cyc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        slv_mode      = 0;
        slv_wait      = 0;
        slv_data      = 32'h0;
        force_ack     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h0;
        bus.cmd_dat   = 32'h0;
        bus.cmd_sel   = 4'h0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_timeout();
        test_bus_error();
        test_back_to_back();
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
